reg_bank_arbiter: RTL and testbench

//  Shares the register bank's single write port and single read port between NUM_REQ requesters
//  (e.g. the AXI4-Lite slave and a local command sequencer). Round-robin, one transaction in flight.

---
 rtl/reg_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/reg_bank_arbiter.sv | 155 +++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// ============================================================================
//  Module   : reg_arb_pkg
//  Brief    : Shared types and constants for the register-bank arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [3:0] RO_IDX  = 4'd3;
    localparam int         IDX_LSB = 2;
    localparam int         IDX_MSB = 5;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick: first request at/after ptr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
                any                                = 1'b1;
                grant[(int'(ptr) + k) % NUM_REQ]   = 1'b1;
                grant_idx                          = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
//  Module   : reg_bank_arbiter
//  Brief    : Round-robin share of the register bank's write/read ports, one
//             transaction in flight, fixed settle window before the response.
//             Optional macro REG_ARB_RO_CHECK_EN rejects writes to word RO_IDX.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  write_en,
    output logic [31:0]           write_addr,
    output logic [31:0]           write_data,
    output logic [31:0]           read_addr,
    input  logic [31:0]           read_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic               lat_write;
    logic               lat_ro;
    logic [CNT_W-1:0]   settle_cnt;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_write;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign sel_addr  = req_addr[32*int'(pick_idx) +: 32];
    assign sel_wdata = req_wdata[32*int'(pick_idx) +: 32];
    assign sel_write = req_write[pick_idx];
    assign ptr_next  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef REG_ARB_RO_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_ro <= 1'b0;
        end else if (state == IDLE && pick_any) begin
            lat_ro <= sel_write && (sel_addr[IDX_MSB:IDX_LSB] == RO_IDX);
        end
    end
    assign rsp_err = (state == RESP) && lat_ro;
`else
    assign lat_ro  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        write_en  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready = pick_onehot;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                write_en  = lat_write && !lat_ro;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[grant_idx] = 1'b1;
                if (rsp_ready[grant_idx]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bank-side address/data registers double as the request latch and keep
    // their value between transactions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_idx  <= '0;
            lat_write  <= 1'b0;
            settle_cnt <= '0;
            write_addr <= '0;
            write_data <= '0;
            read_addr  <= '0;
            rsp_rdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx <= pick_idx;
                        lat_write <= sel_write;
                        if (sel_write) begin
                            write_addr <= sel_addr;
                            write_data <= sel_wdata;
                        end else begin
                            read_addr <= sel_addr;
                        end
                    end
                end
                ISSUE: settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        rsp_rdata <= lat_write ? 32'd0 : read_data;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_idx]) ptr <= ptr_next;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
//  Module   : tb_reg_bank_arbiter
//  Brief    : Self-checking bench: bank model + transaction-timeline model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_arbiter;

    localparam int N = 2;
    localparam int S = 2;
`ifdef REG_ARB_RO_CHECK_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*32-1:0] req_addr  = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_ready = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            write_en;
    logic [31:0]     write_addr;
    logic [31:0]     write_data;
    logic [31:0]     read_addr;
    logic [31:0]     read_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    reg_bank_arbiter #(
        .NUM_REQ       (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank: word 2 with data 1 = ADD (word3 <= word0 + word1); word 3 read-only.
    logic [31:0] bank [16] = '{default: '0};
    always @(posedge clk) begin
        if (write_en) begin
            if (write_addr[5:2] == 4'd2 && write_data == 32'd1)
                bank[3] <= bank[0] + bank[1];
            else if (write_addr[5:2] != 4'd3)
                bank[write_addr[5:2]] <= write_data;
        end
    end
    assign read_data = bank[read_addr[5:2]];

    // Model: a transaction is described by its age in cycles since acceptance.
    logic [31:0] mbank [16] = '{default: '0};
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_g    = 0;
    int          m_ptr  = 0;
    bit          m_wr   = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] m_waddr = '0, m_wout = '0, m_raddr = '0, m_rdata = '0;

    int grants[$];
    int acc_cyc = 0, we_cyc = 0, rv_cyc = 0, we_cnt = 0, rv1_cnt = 0, hs1_cyc = 0, g0_cyc = 0;
    bit rv_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic compare_cycle();
        logic [N-1:0] e_ready, e_rv;
        logic         e_we, e_blk;
        int           p;
        if (!reset_n) begin
            m_busy = 1'b0; m_age = 0; m_ptr = 0;
            m_waddr = '0; m_wout = '0; m_raddr = '0; m_rdata = '0;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_write_en", 32'(write_en), 32'd0);
            chk("rst_write_addr", write_addr, 32'd0);
            chk("rst_write_data", write_data, 32'd0);
            chk("rst_read_addr", read_addr, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
            rv_prev = 1'b0;
            return;
        end
        e_ready = '0; e_rv = '0; e_we = 1'b0; p = -1;
        e_blk = RO_EN && m_wr && (m_addr[5:2] == 4'd3);
        if (!m_busy) begin
            p = rr_pick(req_valid, m_ptr);
            if (p >= 0) e_ready[p] = 1'b1;
        end else begin
            if (m_age == 1 && m_wr && !e_blk) e_we = 1'b1;
            if (m_age >= S + 2) e_rv[m_g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("write_en", 32'(write_en), 32'(e_we));
        chk("write_addr", write_addr, m_waddr);
        chk("write_data", write_data, m_wout);
        chk("read_addr", read_addr, m_raddr);
        if (e_rv != '0) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e_blk));
        end
        // event log for the directed timing checks
        for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
        if (req_ready != '0) acc_cyc = cyc;
        if (req_ready[0]) g0_cyc = cyc;
        if (write_en) begin we_cnt++; we_cyc = cyc; end
        if (rsp_valid != '0 && !rv_prev) rv_cyc = cyc;
        rv_prev = (rsp_valid != '0);
        if (rsp_valid[1]) rv1_cnt++;
        if (rsp_valid[1] && rsp_ready[1]) hs1_cyc = cyc;
        // advance the model across the coming edge
        if (!m_busy) begin
            if (p >= 0) begin
                m_busy = 1'b1; m_age = 1; m_g = p; m_wr = req_write[p];
                m_addr = req_addr[p*32 +: 32]; m_wdata = req_wdata[p*32 +: 32];
                if (m_wr) begin m_waddr = m_addr; m_wout = m_wdata; end
                else m_raddr = m_addr;
            end
        end else if (m_age >= S + 2) begin
            if (rsp_ready[m_g]) begin m_busy = 1'b0; m_ptr = (m_g + 1) % N; end
        end else begin
            if (e_we) begin
                if (m_addr[5:2] == 4'd2 && m_wdata == 32'd1) mbank[3] = mbank[0] + mbank[1];
                else if (m_addr[5:2] != 4'd3) mbank[m_addr[5:2]] = m_wdata;
            end
            if (m_age == S + 1) m_rdata = m_wr ? 32'd0 : mbank[m_addr[5:2]];
            m_age++;
        end
    endtask

    task automatic txn(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output logic er);
        int n;
        rd = '0; er = 1'b0;
        req_write[r] = wr; req_addr[r*32 +: 32] = a; req_wdata[r*32 +: 32] = d;
        rsp_ready[r] = (hold == 0); req_valid[r] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[r] && n < 200);
        if (!req_ready[r]) begin timeout_fail("req_ready_wait"); req_valid[r] = 1'b0; return; end
        @(posedge clk); #1; req_valid[r] = 1'b0;
        n = 0;
        while (!rsp_valid[r] && n < 200) begin @(negedge clk); n++; end
        if (!rsp_valid[r]) begin timeout_fail("rsp_valid_wait"); return; end
        rd = rsp_rdata; er = rsp_err;
        if (hold > 0) begin repeat (hold) @(posedge clk); #1; rsp_ready[r] = 1'b1; end
        @(posedge clk); #1; rsp_ready[r] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          s0, w0, v0, n;

        fork
            forever begin @(negedge clk); compare_cycle(); end
        join_none

        repeat (3) @(posedge clk); #1;
        chk("reset_read_addr", read_addr, 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk); #2; reset_n = 1'b1;
        @(posedge clk); #1;

        // grant order with both requesters continuously valid
        s0 = grants.size();
        fork
            for (int i = 0; i < 2; i++) begin
                logic [31:0] r0; logic e0;
                txn(0, 1'b0, 32'h0, 32'h0, 0, r0, e0);
            end
            for (int i = 0; i < 2; i++) begin
                logic [31:0] r1; logic e1;
                txn(1, 1'b0, 32'h4, 32'h0, 0, r1, e1);
            end
        join
        chk("t2_grant0", 32'(grants[s0]), 32'd0);
        chk("t2_grant1", 32'(grants[s0+1]), 32'd1);
        chk("t2_grant2", 32'(grants[s0+2]), 32'd0);
        chk("t2_grant3", 32'(grants[s0+3]), 32'd1);

        // single write: strobe timing and response latency
        w0 = we_cnt;
        txn(0, 1'b1, 32'h0, 32'h5, 0, rd, er);
        chk("t1_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("t1_we_latency", 32'(we_cyc - acc_cyc), 32'd1);
        chk("t1_rsp_latency", 32'(rv_cyc - acc_cyc), 32'd4);
        chk("t1_err", 32'(er), 32'd0);

        // ALU sequence through the bank
        txn(0, 1'b1, 32'h0, 32'h3, 0, rd, er);
        txn(1, 1'b1, 32'h4, 32'h4, 0, rd, er);
        txn(0, 1'b1, 32'h8, 32'h1, 0, rd, er);
        txn(1, 1'b0, 32'hC, 32'h0, 0, rd, er);
        chk("t3_add_result", rd, 32'h0000_0007);

        // write to the read-only word
        w0 = we_cnt;
        txn(0, 1'b1, 32'hC, 32'hFFFF_FFFF, 0, rd, er);
        chk("t4_err", 32'(er), RO_EN ? 32'd1 : 32'd0);
        chk("t4_we_pulses", 32'(we_cnt - w0), RO_EN ? 32'd0 : 32'd1);
        chk("t4_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'hC, 32'h0, 0, rd, er);
        chk("t4_readback", rd, 32'h0000_0007);

        // response back-pressure on requester 1 while requester 0 waits
        v0 = rv1_cnt;
        fork
            begin
                logic [31:0] r1; logic e1;
                txn(1, 1'b0, 32'h0, 32'h0, 10, r1, e1);
            end
            begin
                logic [31:0] r0; logic e0;
                repeat (3) @(posedge clk); #1;
                txn(0, 1'b0, 32'h4, 32'h0, 0, r0, e0);
            end
        join
        chk("t5_rsp_hold", 32'(rv1_cnt - v0), 32'd11);
        chk("t5_grant_after_hs", 32'(g0_cyc - hs1_cyc), 32'd1);

        // reset during SETTLE
        req_write[0] = 1'b0; req_addr[31:0] = 32'hC; req_valid[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 200);
        if (!req_ready[0]) timeout_fail("t6_ready_wait");
        @(posedge clk); #1; req_valid[0] = 1'b0;
        @(posedge clk); #3; reset_n = 1'b0;
        #1;
        chk("t6_read_addr", read_addr, 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_write_en", 32'(write_en), 32'd0);
        repeat (2) @(negedge clk); #2; reset_n = 1'b1;
        @(posedge clk); #1;
        s0 = grants.size();
        fork
            begin
                logic [31:0] r0; logic e0;
                txn(0, 1'b0, 32'hC, 32'h0, 0, r0, e0);
                chk("t6_rdata", r0, 32'h0000_0007);
            end
            begin
                logic [31:0] r1; logic e1;
                txn(1, 1'b0, 32'h4, 32'h0, 0, r1, e1);
            end
        join
        chk("t6_first_grant", 32'(grants[s0]), 32'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
